// File: rtl/tawas_regfile_pkg.sv
// tawas_regfile_pkg: shared constants and the external return entry type
package tawas_regfile_pkg;
  localparam int WR_IMM = 0;
  localparam int WR_PTR = 1;
  localparam int WR_AU = 2;
  localparam int WR_LD = 3;
  localparam int EXT_AXI = 0;
  localparam int EXT_RACCOON = 1;
  // Field widths are upper bounds; narrower configurations zero-extend into them.
  localparam int EXT_SW = 8;
  localparam int EXT_RW = 8;
  localparam int EXT_DWM = 64;
  typedef struct packed {
    logic [EXT_SW-1:0] slice;
    logic [EXT_RW-1:0] sel;
    logic [EXT_DWM-1:0] data;
  } ext_entry_t;
endpackage

// File: rtl/tawas_regfile_fifo.sv
// tawas_regfile_fifo: synchronous FIFO with occupancy count
module tawas_regfile_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
)(
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/tawas_regfile_sb.sv
// tawas_regfile_sb: multi-slice register file with buffered load returns and a pending-load scoreboard
module tawas_regfile_sb
  import tawas_regfile_pkg::*;
#(
  parameter int SLICES = 4,
  parameter int REGS = 8,
  parameter int DW = 32,
  parameter int PCW = 24,
  parameter int LINK_REG = 6,
  parameter int EXT_DEPTH = 4
)(
  input logic CLK,
  input logic RST,
  input logic [$clog2(SLICES)-1:0] SLICE,
  input logic [4*$clog2(REGS)-1:0] RD_SEL,
  input logic [3:0] RD_USE,
  output logic [4*DW-1:0] RD_DATA,
  output logic RD_STALL,
  input logic PC_STORE,
  input logic [PCW-1:0] PC,
  output logic [PCW-1:0] PC_RTN,
  input logic [3:0] WR_VLD,
  input logic [4*$clog2(REGS)-1:0] WR_SEL,
  input logic [4*DW-1:0] WR_DATA,
  input logic PEND_SET,
  input logic [$clog2(SLICES)-1:0] PEND_SLICE,
  input logic [$clog2(REGS)-1:0] PEND_SEL,
  input logic [1:0] EXT_VLD,
  output logic [1:0] EXT_RDY,
  input logic [2*$clog2(SLICES)-1:0] EXT_SLICE,
  input logic [2*$clog2(REGS)-1:0] EXT_SEL,
  input logic [2*DW-1:0] EXT_DATA,
  output logic PEND_ERR
);
  localparam int SW = $clog2(SLICES);
  localparam int RW = $clog2(REGS);
  localparam int CW = $clog2(EXT_DEPTH+1);
  localparam logic [RW-1:0] LINK = RW'(LINK_REG);
  logic [DW-1:0] rf [SLICES][REGS];
  logic [REGS-1:0] pend [SLICES];
  logic err, ptr, pick, coll, drain;
  logic [SW-1:0] rs, ds;
  logic [RW-1:0] dr;
  logic [DW-1:0] dd;
  logic [SW-1:0] ws [4];
  logic [RW-1:0] wsel [4];
  logic [DW-1:0] wdat [4];
  ext_entry_t ext_in [2];
  ext_entry_t ext_out [2];
  ext_entry_t head;
  logic [1:0] ext_full, ext_empty, pop;
  logic [CW-1:0] ext_cnt [2];
  for (genvar c = EXT_AXI; c <= EXT_RACCOON; c++) begin : g_ext
    assign ext_in[c] = '{slice: EXT_SW'(EXT_SLICE[c*SW +: SW]), sel: EXT_RW'(EXT_SEL[c*RW +: RW]),
                         data: EXT_DWM'(EXT_DATA[c*DW +: DW])};
    tawas_regfile_fifo #(.W($bits(ext_entry_t)), .DEPTH(EXT_DEPTH)) u_fifo (
      .clk(CLK),
      .rst(RST),
      .push(EXT_VLD[c] & ~ext_full[c]),
      .pop(pop[c]),
      .din(ext_in[c]),
      .dout(ext_out[c]),
      .full(ext_full[c]),
      .empty(ext_empty[c]),
      .count(ext_cnt[c])
    );
  end
  // Port k lags the issue slot by k+1 slices; the ext head drains only when no pipeline/PC write targets it.
  always_comb begin
    rs = SLICE - SW'(1);
    for (int k = WR_IMM; k <= WR_LD; k++) begin
      ws[k] = SLICE - SW'(k + 1);
      wsel[k] = WR_SEL[k*RW +: RW];
      wdat[k] = WR_DATA[k*DW +: DW];
    end
    pick = ext_empty[ptr] ? ~ptr : ptr;
    head = ext_out[pick];
    ds = head.slice[SW-1:0];
    dr = head.sel[RW-1:0];
    dd = head.data[DW-1:0];
    coll = PC_STORE && rs == ds && LINK == dr;
    for (int k = WR_IMM; k <= WR_LD; k++) coll |= WR_VLD[k] && ws[k] == ds && wsel[k] == dr;
    drain = ~&ext_empty & ~coll;
    pop = {pick, ~pick} & {2{drain}};
  end
  always_comb begin
    RD_DATA = '0;
    RD_STALL = 1'b0;
    for (int k = 0; k < 4; k++) begin
      RD_DATA[k*DW +: DW] = RST ? '0 : rf[rs][RD_SEL[k*RW +: RW]];
      RD_STALL |= RD_USE[k] & pend[rs][RD_SEL[k*RW +: RW]] & ~RST;
    end
    PC_RTN = RST ? '0 : rf[rs][LINK][PCW-1:0];
    EXT_RDY = RST ? 2'b11 : ~ext_full;
    PEND_ERR = err;
  end
  // Later assignments win, giving port 3 > 2 > 1 > 0 > PC_STORE > drain and set-over-clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SLICES; s++) begin
        pend[s] <= '0;
        for (int r = 0; r < REGS; r++) rf[s][r] <= '0;
      end
      ptr <= 1'b0;
      err <= 1'b0;
    end else begin
      if (drain) begin
        rf[ds][dr] <= dd;
        pend[ds][dr] <= 1'b0;
        ptr <= ~pick;
      end
      if (PC_STORE) rf[rs][LINK] <= DW'(PC);
      for (int k = WR_IMM; k <= WR_LD; k++) if (WR_VLD[k]) rf[ws[k]][wsel[k]] <= wdat[k];
      if (PEND_SET) pend[PEND_SLICE][PEND_SEL] <= 1'b1;
      if ((PEND_SET && pend[PEND_SLICE][PEND_SEL]) || (drain && !pend[ds][dr])) err <= 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!drain || head == ext_entry_t'{EXT_SW'(ds), EXT_RW'(dr), EXT_DWM'(dd)});
      for (int c = EXT_AXI; c <= EXT_RACCOON; c++) assert ((ext_cnt[c] == '0) == ext_empty[c]);
    end
  end
endmodule
